log_calc_mc: RTL and testbench
==============================

// Module: log_calc_mc
// PURPOSE
//  Multi-channel, fully pipelined power-to-dB converter; successor to log_calc.
//  Takes an unsigned linear power sample tagged with a channel number and
//  produces 10*log10(power)+OFFSET as signed fixed point, one sample per clock.
//  Sits after the per-channel power accumulators and feeds the dBm reporting path.
// PARAMETERS
//  IN_W      32   width of unsigned power input
//  NUM_CH    4    number of channels; CH_W = $clog2(NUM_CH), minimum 1
//  FRAC_W    8    fractional bits of the internal log2 value (mantissa bits kept)
//  OUT_W     16   width of signed dB output
//  OUT_FRAC  8    fractional bits of dB output (Q(OUT_W-OUT_FRAC).OUT_FRAC)
//  OFFSET    0    signed calibration offset added to result, in output LSBs
// PORTS
//  clk        in   1       clock; all logic on rising edge
//  rst        in   1       synchronous reset, active high
//  valid_in   in   1       power/chan_in valid this cycle
//  power      in   IN_W    unsigned linear power
//  chan_in    in   CH_W    channel tag
//  valid_out  out  1       dbm_value/chan_out valid
//  dbm_value  out  OUT_W   signed dB result
//  chan_out   out  CH_W    channel tag aligned with dbm_value
//  zero_flag  out  1       sample was power==0 (dbm_value forced to MIN)
//  sat_flag   out  1       result clipped to MIN/MAX by offset addition
//  peak_sel   in   CH_W    peak readback channel     (LOG_CALC_PEAK_HOLD_EN only)
//  peak_clr   in   1       clear peak of peak_sel    (LOG_CALC_PEAK_HOLD_EN only)
//  peak_out   out  OUT_W   registered peak of peak_sel (LOG_CALC_PEAK_HOLD_EN only)
// BEHAVIOUR
//  - No backpressure; accepts one sample every cycle; latency exactly 5 clocks
//    from valid_in to valid_out. chan_out = chan_in of same sample.
//  - Invalid cycles propagate as bubbles; data regs only load when valid.
//  - S1: register power, chan, valid.
//  - S2: k = index of leading one (0..IN_W-1); m = next FRAC_W bits below the
//    leading one, zero-padded on the right if fewer exist (truncate, no round).
//  - S3: L = (k << FRAC_W) | m  (Mitchell log2 approx, unsigned).
//  - S4: P = L * 197283 (= round(10*log10(2)*2^16)); D = P >> (FRAC_W+16-OUT_FRAC),
//    floor (truncation).
//  - S5: R = D + OFFSET with full precision; clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
//    sat_flag=1 when clipped.
//  - power==0: dbm_value = -2^(OUT_W-1) (MIN), zero_flag=1, sat_flag=0, OFFSET ignored.
//  - Flags are qualified by valid_out; hold last value otherwise.
//  - Reset: valid pipe cleared; valid_out, dbm_value, chan_out, zero_flag, sat_flag = 0.
//    Reset mid-stream discards all in-flight samples; first valid_out 5 clocks
//    after the first valid_in accepted after rst deasserts.
// CONFIGURATION
//  LOG_CALC_PEAK_HOLD_EN defined: per-channel peak register, reset to MIN.
//   - On valid_out, peak[chan_out] <= max(peak[chan_out], dbm_value) (signed).
//   - peak_clr sets peak[peak_sel] <= MIN; if same cycle an update hits the same
//     channel, the update value is loaded instead (update wins).
//   - peak_out <= peak[peak_sel] each clock (1-cycle read latency); 0 in reset.
//  Not defined: peak ports, peak registers and logic absent; rest unchanged.
// TESTING  (defaults, OFFSET=0 unless stated)
//  power=1, chan 0 -> 5 clocks later valid_out=1, dbm_value=0, chan_out=0.
//  power=3 -> 1155 (0x0483); power=1024 -> 7706 (0x1E1A); power=0xFFFFFFFF -> 24657.
//  power=0 -> dbm_value=0x8000, zero_flag=1; OFFSET=-7706, power=1024 -> 0;
//   OFFSET=30000, power=0xFFFFFFFF -> 0x7FFF, sat_flag=1.
//  Back-to-back 8 samples, chans 0..3 cycling, bubble every 3rd cycle -> outputs
//   in order, same bubble pattern, tags intact, no drops.
//  rst pulsed for 1 clock with 3 samples in flight -> none emerge; next sample
//   appears exactly 5 clocks after its valid_in.
//  PEAK_HOLD_EN: ch2 gets 3,1024,1 -> peak_sel=2 reads 7706; peak_clr -> 0x8000;
//   clr coincident with ch2 update of 1155 -> peak reads 1155.

Source files
------------

// File: rtl/log_calc_mc.sv
// log_calc_mc: multi-channel pipelined power-to-dB converter (Mitchell log2), 5-cycle latency.
// Define LOG_CALC_PEAK_HOLD_EN to add per-channel peak hold with peak_sel/peak_clr/peak_out.
module log_calc_mc #(
  parameter int unsigned IN_W     = 32,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned FRAC_W   = 8,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned OUT_FRAC = 8,
  parameter int          OFFSET   = 0,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [IN_W-1:0]   power,
  input  logic [CH_W-1:0]   chan_in,
  output logic              valid_out,
  output logic [OUT_W-1:0]  dbm_value,
  output logic [CH_W-1:0]   chan_out,
  output logic              zero_flag,
  output logic              sat_flag
`ifdef LOG_CALC_PEAK_HOLD_EN
  ,
  input  logic [CH_W-1:0]   peak_sel,
  input  logic              peak_clr,
  output logic [OUT_W-1:0]  peak_out
`endif
);

  localparam int unsigned K_W   = $clog2(IN_W);
  localparam int unsigned L_W   = K_W + FRAC_W;
  localparam int unsigned C_W   = 18;
  localparam int unsigned P_W   = L_W + C_W;
  localparam int unsigned SHIFT = FRAC_W + 16 - OUT_FRAC;
  localparam int unsigned D_W   = P_W - SHIFT;
  localparam int unsigned R_W   = D_W + 34;
  localparam int unsigned EXT_W = IN_W + FRAC_W;

  // round(10*log10(2) * 2^16)
  localparam logic [C_W-1:0] LOG_SCALE = 18'd197283;
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = ~OUT_MIN;
  localparam logic signed [R_W-1:0] MAX_R = R_W'(2**(OUT_W-1) - 1);
  localparam logic signed [R_W-1:0] MIN_R = -MAX_R - R_W'(1);

  logic [4:0]        vld_q, vld_d;
  logic [IN_W-1:0]   pwr1_q, pwr1_d;
  logic [CH_W-1:0]   ch1_q, ch1_d, ch2_q, ch2_d, ch3_q, ch3_d, ch4_q, ch4_d, ch5_q, ch5_d;
  logic [K_W-1:0]    k2_q, k2_d;
  logic [FRAC_W-1:0] m2_q, m2_d;
  logic              zero2_q, zero2_d, zero3_q, zero3_d, zero4_q, zero4_d, zero5_q, zero5_d;
  logic [L_W-1:0]    l3_q, l3_d;
  logic [D_W-1:0]    d4_q, d4_d;
  logic [OUT_W-1:0]  dbm5_q, dbm5_d;
  logic              sat5_q, sat5_d;

  logic [K_W-1:0]          k_c;
  logic [EXT_W-1:0]        ext_c;
  logic [P_W-1:0]          p_c;
  logic signed [R_W-1:0]   r_c;

  // Pipeline datapath; each stage's data registers load only behind a valid sample.
  always_comb begin
    vld_d = {vld_q[3:0], valid_in};

    pwr1_d = valid_in ? power   : pwr1_q;
    ch1_d  = valid_in ? chan_in : ch1_q;

    k_c = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (pwr1_q[i]) k_c = K_W'(i);
    end
    ext_c   = {pwr1_q, {FRAC_W{1'b0}}} << (K_W'(IN_W - 1) - k_c);
    k2_d    = vld_q[0] ? k_c                          : k2_q;
    m2_d    = vld_q[0] ? ext_c[EXT_W-2 -: FRAC_W]     : m2_q;
    zero2_d = vld_q[0] ? (pwr1_q == '0)               : zero2_q;
    ch2_d   = vld_q[0] ? ch1_q                        : ch2_q;

    l3_d    = vld_q[1] ? {k2_q, m2_q} : l3_q;
    zero3_d = vld_q[1] ? zero2_q      : zero3_q;
    ch3_d   = vld_q[1] ? ch2_q        : ch3_q;

    p_c     = P_W'(l3_q) * P_W'(LOG_SCALE);
    d4_d    = vld_q[2] ? D_W'(p_c >> SHIFT) : d4_q;
    zero4_d = vld_q[2] ? zero3_q            : zero4_q;
    ch4_d   = vld_q[2] ? ch3_q              : ch4_q;

    r_c     = R_W'(d4_q) + R_W'(OFFSET);
    dbm5_d  = dbm5_q;
    sat5_d  = sat5_q;
    zero5_d = zero5_q;
    ch5_d   = ch5_q;
    if (vld_q[3]) begin
      ch5_d   = ch4_q;
      zero5_d = zero4_q;
      sat5_d  = 1'b0;
      if (zero4_q) begin
        dbm5_d = OUT_MIN;
      end else if (r_c > MAX_R) begin
        dbm5_d = OUT_MAX;
        sat5_d = 1'b1;
      end else if (r_c < MIN_R) begin
        dbm5_d = OUT_MIN;
        sat5_d = 1'b1;
      end else begin
        dbm5_d = OUT_W'(r_c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      pwr1_q  <= '0;
      ch1_q   <= '0;
      k2_q    <= '0;
      m2_q    <= '0;
      zero2_q <= 1'b0;
      ch2_q   <= '0;
      l3_q    <= '0;
      zero3_q <= 1'b0;
      ch3_q   <= '0;
      d4_q    <= '0;
      zero4_q <= 1'b0;
      ch4_q   <= '0;
      dbm5_q  <= '0;
      sat5_q  <= 1'b0;
      zero5_q <= 1'b0;
      ch5_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      pwr1_q  <= pwr1_d;
      ch1_q   <= ch1_d;
      k2_q    <= k2_d;
      m2_q    <= m2_d;
      zero2_q <= zero2_d;
      ch2_q   <= ch2_d;
      l3_q    <= l3_d;
      zero3_q <= zero3_d;
      ch3_q   <= ch3_d;
      d4_q    <= d4_d;
      zero4_q <= zero4_d;
      ch4_q   <= ch4_d;
      dbm5_q  <= dbm5_d;
      sat5_q  <= sat5_d;
      zero5_q <= zero5_d;
      ch5_q   <= ch5_d;
    end
  end

  assign valid_out = vld_q[4];
  assign dbm_value = dbm5_q;
  assign chan_out  = ch5_q;
  assign zero_flag = zero5_q;
  assign sat_flag  = sat5_q;

`ifdef LOG_CALC_PEAK_HOLD_EN
  logic [OUT_W-1:0] peak_q [NUM_CH];
  logic [OUT_W-1:0] peak_d [NUM_CH];
  logic [OUT_W-1:0] peak_out_q, peak_out_d;

  // An output update to a channel takes priority over a coincident clear of it.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      peak_d[c] = peak_q[c];
      if (vld_q[4] && (ch5_q == CH_W'(c))) begin
        peak_d[c] = ($signed(dbm5_q) > $signed(peak_q[c])) ? dbm5_q : peak_q[c];
      end else if (peak_clr && (peak_sel == CH_W'(c))) begin
        peak_d[c] = OUT_MIN;
      end
    end
    peak_out_d = peak_q[peak_sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) peak_q[c] <= OUT_MIN;
      peak_out_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) peak_q[c] <= peak_d[c];
      peak_out_q <= peak_out_d;
    end
  end

  assign peak_out = peak_out_q;
`endif

endmodule

// File: tb/tb_log_calc_mc.sv
// Scoreboard bench for log_calc_mc: three instances with OFFSET 0, -7706 and 30000 share stimulus.
// Peak-hold checks run when LOG_CALC_PEAK_HOLD_EN is defined.
module tb_log_calc_mc;

  typedef struct {
    logic [15:0] dbm;
    logic [1:0]  ch;
    logic        zero;
    logic        sat;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] power;
  logic [1:0]  chan_in;
  logic        vo  [3];
  logic [15:0] dbm [3];
  logic [1:0]  cho [3];
  logic        zf  [3];
  logic        sf  [3];
  logic [1:0]  peak_sel;
  logic        peak_clr;
  logic [15:0] pk  [3];

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic        rst_req = 1'b0;
  logic        drain_req = 1'b0;
  logic        peak_req = 1'b0;
  logic [15:0] peak_exp = '0;
  exp_t        sb [3][$];
  exp_t        mon_e;
  logic        mon_v;

  // Directed vectors: power and hand-computed dB (OFFSET=0, Q8.8).
  logic [31:0] vp [9] = '{32'd1, 32'd3, 32'd1024, 32'hFFFF_FFFF, 32'd0, 32'd2, 32'd5, 32'd1000, 32'h8000_0000};
  int          vd [9] = '{0, 1155, 7706, 24657, 0, 770, 1733, 7670, 23889};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  log_calc_mc #(.OFFSET(0)) u_dut0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .power(power), .chan_in(chan_in),
    .valid_out(vo[0]), .dbm_value(dbm[0]), .chan_out(cho[0]), .zero_flag(zf[0]), .sat_flag(sf[0])
`ifdef LOG_CALC_PEAK_HOLD_EN
    , .peak_sel(peak_sel), .peak_clr(peak_clr), .peak_out(pk[0])
`endif
  );

  log_calc_mc #(.OFFSET(-7706)) u_dut1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .power(power), .chan_in(chan_in),
    .valid_out(vo[1]), .dbm_value(dbm[1]), .chan_out(cho[1]), .zero_flag(zf[1]), .sat_flag(sf[1])
`ifdef LOG_CALC_PEAK_HOLD_EN
    , .peak_sel(peak_sel), .peak_clr(peak_clr), .peak_out(pk[1])
`endif
  );

  log_calc_mc #(.OFFSET(30000)) u_dut2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .power(power), .chan_in(chan_in),
    .valid_out(vo[2]), .dbm_value(dbm[2]), .chan_out(cho[2]), .zero_flag(zf[2]), .sat_flag(sf[2])
`ifdef LOG_CALC_PEAK_HOLD_EN
    , .peak_sel(peak_sel), .peak_clr(peak_clr), .peak_out(pk[2])
`endif
  );

  function automatic int off_of(input int i);
    case (i)
      1:       return -7706;
      2:       return 30000;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t mk(input int off, input logic [31:0] p, input int d0,
                              input logic [1:0] c, input int unsigned cy);
    exp_t e;
    int   r;
    e.ch   = c;
    e.cyc  = cy;
    e.zero = (p == 32'd0);
    e.sat  = 1'b0;
    r      = d0 + off;
    if (p == 32'd0) begin
      e.dbm = 16'h8000;
    end else if (r > 32767) begin
      e.dbm = 16'h7FFF;
      e.sat = 1'b1;
    end else if (r < -32768) begin
      e.dbm = 16'h8000;
      e.sat = 1'b1;
    end else begin
      e.dbm = 16'(r);
    end
    return e;
  endfunction

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Drive one sample for one cycle; each output is due exactly 5 clocks later.
  task automatic send(input logic [31:0] p, input logic [1:0] c, input int d0);
    valid_in = 1'b1;
    power    = p;
    chan_in  = c;
    for (int i = 0; i < 3; i++) sb[i].push_back(mk(off_of(i), p, d0, c, cyc + 5));
    idle();
    valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; k++) idle();
    drain_req = 1'b1;
    idle();
    drain_req = 1'b0;
  endtask

  // Monitor: cycle-exact valid check plus payload compare against the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        mon_v = (sb[i].size() > 0) && (sb[i][0].cyc == cyc);
        checks++;
        if (vo[i] !== mon_v) begin
          errors++;
          $display("FAIL valid_out dut%0d cyc %0d: got %b want %b", i, cyc, vo[i], mon_v);
        end
        if (mon_v) begin
          mon_e = sb[i].pop_front();
          checks++;
          if ({dbm[i], cho[i], zf[i], sf[i]} !== {mon_e.dbm, mon_e.ch, mon_e.zero, mon_e.sat}) begin
            errors++;
            $display("FAIL output dut%0d cyc %0d: got dbm=%h ch=%0d zero=%b sat=%b want dbm=%h ch=%0d zero=%b sat=%b",
                     i, cyc, dbm[i], cho[i], zf[i], sf[i], mon_e.dbm, mon_e.ch, mon_e.zero, mon_e.sat);
          end
        end
        if (rst_req) begin
          checks++;
          if ({vo[i], dbm[i], cho[i], zf[i], sf[i]} !== 21'd0) begin
            errors++;
            $display("FAIL reset_state dut%0d: got v=%b dbm=%h ch=%0d zero=%b sat=%b want all 0",
                     i, vo[i], dbm[i], cho[i], zf[i], sf[i]);
          end
        end
      end
      if (drain_req) begin
        checks++;
        if ((sb[0].size() + sb[1].size() + sb[2].size()) != 0) begin
          errors++;
          $display("FAIL drain: got %0d outstanding want 0", sb[0].size() + sb[1].size() + sb[2].size());
        end
      end
`ifdef LOG_CALC_PEAK_HOLD_EN
      if (peak_req) begin
        checks++;
        if (pk[0] !== peak_exp) begin
          errors++;
          $display("FAIL peak_out: got %h want %h", pk[0], peak_exp);
        end
      end
`endif
    end
  end

  initial begin
    int unsigned n0;
    int          n;
    rst      = 1'b1;
    valid_in = 1'b0;
    power    = '0;
    chan_in  = '0;
    peak_sel = '0;
    peak_clr = 1'b0;
    repeat (3) idle();
    rst     = 1'b0;
    rst_req = 1'b1;
    mon_en  = 1'b1;
    idle();
    rst_req = 1'b0;

`ifdef LOG_CALC_PEAK_HOLD_EN
    send(32'd3, 2'd2, 1155);
    send(32'd1024, 2'd2, 7706);
    send(32'd1, 2'd2, 0);
    drain();
    peak_sel = 2'd2;
    repeat (2) idle();
    peak_exp = 16'd7706;
    peak_req = 1'b1;
    idle();
    peak_req = 1'b0;
    peak_clr = 1'b1;
    idle();
    peak_clr = 1'b0;
    repeat (2) idle();
    peak_exp = 16'h8000;
    peak_req = 1'b1;
    idle();
    peak_req = 1'b0;
    n0 = cyc;
    send(32'd3, 2'd2, 1155);
    while (cyc < n0 + 5) idle();
    peak_clr = 1'b1;
    idle();
    peak_clr = 1'b0;
    repeat (2) idle();
    peak_exp = 16'd1155;
    peak_req = 1'b1;
    idle();
    peak_req = 1'b0;
    drain();
`endif

    // Back-to-back directed vectors across all channels.
    for (int i = 0; i < 9; i++) send(vp[i], 2'(i), vd[i]);
    drain();

    // Eight samples with a bubble on every third cycle.
    n = 0;
    for (int i = 0; n < 8; i++) begin
      if (i % 3 == 2) begin
        idle();
      end else begin
        send(vp[n], 2'(n), vd[n]);
        n++;
      end
    end
    drain();

    // Reset with three samples in flight: none may emerge.
    send(32'd1024, 2'd0, 7706);
    send(32'd3, 2'd1, 1155);
    send(32'hFFFF_FFFF, 2'd2, 24657);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) sb[i].delete();
    idle();
    rst     = 1'b0;
    rst_req = 1'b1;
    idle();
    rst_req = 1'b0;
    repeat (6) idle();
    send(32'd1024, 2'd3, 7706);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
